ac_seq: RTL and testbench
=========================

// Module: ac_seq
// PURPOSE
//  Micro-sequencer for the DAPA2014 accumulator/ALU datapath. Accepts one
//  accumulator instruction per start pulse and drives the accumulator
//  controls (wac, rac, source select), the ALU op, the flag write and the
//  data-bus request. It sits between the instruction decoder and the
//  ac/ALU pair. Multi-bit shifts run as repeated 1-bit shifts.
// PARAMETERS
//  CNT_W   3   width of the shift-amount field and counter (max shift 2^CNT_W-1)
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-high; returns block to IDLE
//  start     in   1      instruction request; sampled only in IDLE
//  op        in   3      opcode: 0 NOP,1 LDA,2 STA,3 ADD,4 SUB,5 AND,6 SHL,7 SHR
//  shamt     in   CNT_W  shift amount for SHL/SHR; ignored otherwise
//  bus_gnt   in   1      data-bus grant from bus arbiter
//  busy      out  1      instruction in progress (EXEC/SHIFT/BUS/DONE)
//  done      out  1      one-cycle completion pulse
//  bus_req   out  1      request data bus for an accumulator store
//  rac       out  1      accumulator tri-state read enable
//  mem_we    out  1      memory write strobe; high exactly with rac
//  wac       out  1      accumulator write enable
//  ac_src    out  1      accumulator input select: 0 = data bus, 1 = ALU result
//  alu_op    out  3      0 PASS,1 ADD,2 SUB,3 AND,4 SHL1,5 SHR1
//  wfl       out  1      flag-register write enable
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, latched op/shamt=0; all outputs 0.
//    Asserting reset mid-instruction aborts it: no done pulse and no further
//    wac/rac.
//  - op and shamt are latched on the edge that accepts start. Inputs are
//    don't-care afterwards. start outside IDLE is ignored (not queued).
//  - Outputs are decoded only from registered state, latched op and
//    counter. Exception: rac/mem_we = (state==BUS) & bus_gnt.
//  - States and transitions:
//    IDLE -> start&op==STA: BUS. start&op in{SHL,SHR}&shamt!=0: SHIFT, cnt<=shamt.
//            Other start: EXEC. No start: stays IDLE.
//    EXEC (1 cycle) -> DONE.
//      LDA: wac=1, ac_src=0.
//      ADD/SUB/AND: wac=1, ac_src=1, alu_op per op, wfl=1.
//      NOP, or shift with shamt=0: no strobes.
//    SHIFT: wac=1, ac_src=1, alu_op=SHL1/SHR1. cnt decrements each cycle.
//      wfl=1 only when cnt==1. Goes to DONE when cnt==1, so there are
//      exactly shamt wac cycles.
//    BUS: bus_req=1. Waits indefinitely for bus_gnt. In the cycle
//      bus_gnt=1: rac=1, mem_we=1, then -> DONE. bus_gnt dropping before
//      the grant cycle has no effect.
//    DONE (1 cycle): done=1, busy=1 -> IDLE.
//  - Latency, start accepted at edge k:
//      EXEC ops: strobes in cycle k+1, done in cycle k+2.
//      Shift N: wac in cycles k+1..k+N, done in cycle k+N+1.
//      STA: done the cycle after the grant cycle.
//  - Minimum issue interval: 3 cycles (IDLE, EXEC, DONE).
//  - Invariants: rac never with wac. wac/wfl never outside EXEC/SHIFT.
//    bus_req only in BUS.
// STRUCTURE
//  - Shared package dapa_pkg:
//      opcode localparams OP_NOP..OP_SHR,
//      ALU op localparams ALU_PASS..ALU_SHR1,
//      state encoding S_IDLE,S_EXEC,S_SHIFT,S_BUS,S_DONE,
//      AC_SRC_BUS/AC_SRC_ALU.
//  - One sub-module, seq_cnt: loadable CNT_W down-counter with async reset.
//    Inputs load, dec, d. Outputs q, one (q==1).
// TESTING
//  1. start,op=ADD at edge 0 -> cycle1: wac=1,ac_src=1,alu_op=1,wfl=1;
//     cycle2: done=1; cycle3: busy=0.
//  2. start,op=SHL,shamt=3 -> wac=1,alu_op=4 in cycles 1-3,
//     wfl only in cycle 3, done in cycle 4. Same with shamt=0 -> no wac,
//     done in cycle 2.
//  3. start,op=STA, bus_gnt held 0 for 5 cycles then 1 -> bus_req=1
//     throughout, rac=mem_we=1 only in the grant cycle, done next cycle.
//  4. start,op=LDA; second start with op=ADD during EXEC/DONE ->
//     second ignored, only one wac (ac_src=0), one done.
//  5. reset asserted asynchronously mid-SHIFT (shamt=7, after 2 wac cycles)
//     -> all outputs 0 immediately, state IDLE, no done. Next ADD runs
//     normally.
//  6. Back-to-back ADD,SUB,AND each started the cycle busy falls ->
//     3-cycle spacing, alu_op 1,2,3 in order, three done pulses.

Source files
------------

// File: rtl/dapa_pkg.sv
// Shared definitions for the DAPA2014 accumulator/ALU datapath.
package dapa_pkg;

  // Accumulator instruction opcodes
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_STA = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_SHL1 = 3'd4;
  localparam logic [2:0] ALU_SHR1 = 3'd5;

  // Accumulator input select
  localparam logic AC_SRC_BUS = 1'b0;
  localparam logic AC_SRC_ALU = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_BUS,
    S_DONE
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // ALU op driven for an instruction; PASS for anything that does not use the ALU
  function automatic logic [2:0] alu_of(input logic [2:0] op);
    unique case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_SHL:  return ALU_SHL1;
      OP_SHR:  return ALU_SHR1;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/seq_cnt.sv
// Loadable down-counter holding the remaining 1-bit shift steps.
module seq_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q,
  output logic             one
);

  logic [CNT_W-1:0] q_q, q_d;

  // Load has priority over decrement
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (dec) begin
      q_d = q_q - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign one = (q_q == CNT_W'(1));

endmodule

// File: rtl/ac_seq.sv
// Micro-sequencer: one accumulator instruction per start, drives ac/ALU controls.
module ac_seq
  import dapa_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] shamt,
  input  logic             bus_gnt,
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  output logic             rac,
  output logic             mem_we,
  output logic             wac,
  output logic             ac_src,
  output logic [2:0]       alu_op,
  output logic             wfl
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTwo = CNT_W'(2);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d, done_q, done_d, bus_req_q, bus_req_d;
  logic             wac_q, wac_d, ac_src_q, ac_src_d, wfl_q, wfl_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             cnt_load, cnt_dec, cnt_one;
  logic [CNT_W-1:0] cnt_q;

  seq_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .d     (shamt),
    .q     (cnt_q),
    .one   (cnt_one)
  );

  // Next state plus the output values that state will present
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bus_req_d = 1'b0;
    wac_d     = 1'b0;
    ac_src_d  = AC_SRC_BUS;
    alu_op_d  = ALU_PASS;
    wfl_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          busy_d = 1'b1;
          if (op == OP_STA) begin
            state_d   = S_BUS;
            bus_req_d = 1'b1;
          end else if (is_shift(op) && (shamt != '0)) begin
            state_d  = S_SHIFT;
            cnt_load = 1'b1;
            wac_d    = 1'b1;
            ac_src_d = AC_SRC_ALU;
            alu_op_d = alu_of(op);
            wfl_d    = (shamt == CntOne);
          end else begin
            // Zero-length shifts fall through here as a strobe-free EXEC
            state_d = S_EXEC;
            unique case (op)
              OP_LDA: begin
                wac_d    = 1'b1;
                ac_src_d = AC_SRC_BUS;
              end
              OP_ADD, OP_SUB, OP_AND: begin
                wac_d    = 1'b1;
                ac_src_d = AC_SRC_ALU;
                alu_op_d = alu_of(op);
                wfl_d    = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
      S_SHIFT: begin
        busy_d  = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_one) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wac_d    = 1'b1;
          ac_src_d = AC_SRC_ALU;
          alu_op_d = alu_of(op_q);
          // Flags only on the final step, which runs once the count reads 1
          wfl_d    = (cnt_q == CntTwo);
        end
      end
      S_BUS: begin
        busy_d = 1'b1;
        if (bus_gnt) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, latched opcode and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bus_req_q <= 1'b0;
      wac_q     <= 1'b0;
      ac_src_q  <= AC_SRC_BUS;
      alu_op_q  <= ALU_PASS;
      wfl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bus_req_q <= bus_req_d;
      wac_q     <= wac_d;
      ac_src_q  <= ac_src_d;
      alu_op_q  <= alu_op_d;
      wfl_q     <= wfl_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bus_req = bus_req_q;
  assign wac     = wac_q;
  assign ac_src  = ac_src_q;
  assign alu_op  = alu_op_q;
  assign wfl     = wfl_q;
  // bus_req_q is high exactly while in BUS, so this is the grant cycle
  assign rac     = bus_req_q & bus_gnt;
  assign mem_we  = bus_req_q & bus_gnt;

endmodule

// File: tb/tb_ac_seq.sv
// Directed bench for ac_seq with hand-computed per-cycle output vectors.
module tb_ac_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [2:0] shamt;
  logic       bus_gnt;
  logic       busy, done, bus_req, rac, mem_we, wac, ac_src, wfl;
  logic [2:0] alu_op;

  int n_cmp = 0;
  int n_err = 0;

  ac_seq #(
    .CNT_W(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .bus_gnt (bus_gnt),
    .busy    (busy),
    .done    (done),
    .bus_req (bus_req),
    .rac     (rac),
    .mem_we  (mem_we),
    .wac     (wac),
    .ac_src  (ac_src),
    .alu_op  (alu_op),
    .wfl     (wfl)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {busy,done,bus_req,rac,mem_we,wac,ac_src,alu_op,wfl}
  logic [10:0] obs;
  assign obs = {busy, done, bus_req, rac, mem_we, wac, ac_src, alu_op, wfl};

  function automatic logic [10:0] ev(input logic b, input logic d, input logic bq,
                                     input logic r, input logic we, input logic w,
                                     input logic src, input logic [2:0] aop,
                                     input logic f);
    return {b, d, bq, r, we, w, src, aop, f};
  endfunction

  localparam logic [10:0] Idle = 11'b0;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (busy,done,breq,rac,we,wac,src,aop[3],wfl)",
               tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge; returns in cycle 1 of the instruction
  task automatic issue(input logic [2:0] o, input logic [2:0] s);
    start = 1'b1;
    op    = o;
    shamt = s;
    tick();
    start = 1'b0;
    op    = 3'd0;
    shamt = 3'd0;
  endtask

  logic [2:0] seq_op  [3] = '{3'd3, 3'd4, 3'd5};
  logic [2:0] seq_aop [3] = '{3'd1, 3'd2, 3'd3};

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'd0;
    shamt   = 3'd0;
    bus_gnt = 1'b0;
    tick();
    tick();
    check("reset_state", obs, Idle);
    reset = 1'b0;
    tick();
    check("idle_after_reset", obs, Idle);

    // 1: ADD
    issue(3'd3, 3'd0);
    check("add_c1", obs, ev(1, 0, 0, 0, 0, 1, 1, 3'd1, 1));
    tick();
    check("add_c2_done", obs, ev(1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
    tick();
    check("add_c3_idle", obs, Idle);

    // 2: SHL by 3, by 0, and SHR by 1
    issue(3'd6, 3'd3);
    check("shl3_c1", obs, ev(1, 0, 0, 0, 0, 1, 1, 3'd4, 0));
    tick();
    check("shl3_c2", obs, ev(1, 0, 0, 0, 0, 1, 1, 3'd4, 0));
    tick();
    check("shl3_c3_wfl", obs, ev(1, 0, 0, 0, 0, 1, 1, 3'd4, 1));
    tick();
    check("shl3_c4_done", obs, ev(1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
    tick();
    check("shl3_c5_idle", obs, Idle);

    issue(3'd6, 3'd0);
    check("shl0_c1", obs, ev(1, 0, 0, 0, 0, 0, 0, 3'd0, 0));
    tick();
    check("shl0_c2_done", obs, ev(1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
    tick();

    issue(3'd7, 3'd1);
    check("shr1_c1", obs, ev(1, 0, 0, 0, 0, 1, 1, 3'd5, 1));
    tick();
    check("shr1_c2_done", obs, ev(1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
    tick();

    // 3: STA with delayed grant; a grant glitch between edges is harmless
    issue(3'd2, 3'd0);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("sta_wait_c%0d", c), obs, ev(1, 0, 1, 0, 0, 0, 0, 3'd0, 0));
      if (c == 3) begin
        bus_gnt = 1'b1;
        #1;
        check("sta_glitch", obs, ev(1, 0, 1, 1, 1, 0, 0, 3'd0, 0));
        bus_gnt = 1'b0;
        #1;
      end
      tick();
    end
    check("sta_c6_pre", obs, ev(1, 0, 1, 0, 0, 0, 0, 3'd0, 0));
    bus_gnt = 1'b1;
    #1;
    check("sta_grant", obs, ev(1, 0, 1, 1, 1, 0, 0, 3'd0, 0));
    tick();
    bus_gnt = 1'b0;
    check("sta_done", obs, ev(1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
    tick();
    check("sta_idle", obs, Idle);

    // 4: LDA with a second start held through EXEC and DONE
    issue(3'd1, 3'd0);
    start = 1'b1;
    op    = 3'd3;
    check("lda_c1", obs, ev(1, 0, 0, 0, 0, 1, 0, 3'd0, 0));
    tick();
    check("lda_c2_done", obs, ev(1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
    start = 1'b0;
    op    = 3'd0;
    tick();
    check("lda_ignored_c3", obs, Idle);
    tick();
    check("lda_ignored_c4", obs, Idle);

    // 5: asynchronous reset mid-SHIFT
    issue(3'd6, 3'd7);
    check("rst_shl_c1", obs, ev(1, 0, 0, 0, 0, 1, 1, 3'd4, 0));
    tick();
    check("rst_shl_c2", obs, ev(1, 0, 0, 0, 0, 1, 1, 3'd4, 0));
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_zero", obs, Idle);
    tick();
    reset = 1'b0;
    tick();
    check("rst_no_done_a", obs, Idle);
    tick();
    check("rst_no_done_b", obs, Idle);
    issue(3'd3, 3'd0);
    check("rst_add_c1", obs, ev(1, 0, 0, 0, 0, 1, 1, 3'd1, 1));
    tick();
    check("rst_add_done", obs, ev(1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
    tick();

    // 6: back-to-back ADD, SUB, AND at the minimum 3-cycle spacing
    for (int i = 0; i < 3; i++) begin
      issue(seq_op[i], 3'd0);
      check($sformatf("b2b%0d_exec", i), obs, ev(1, 0, 0, 0, 0, 1, 1, seq_aop[i], 1));
      tick();
      check($sformatf("b2b%0d_done", i), obs, ev(1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
      tick();
      check($sformatf("b2b%0d_free", i), obs, Idle);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
